norm_datapath: RTL
==================

# norm_datapath

Iterative left-normalizing datapath that consumes the `load_t`/`sel_t` strobes issued by the gate-level controller FSM and returns `datapath_done` to it. It captures an operand into register T, shifts T left one bit per controller-requested step until the MSB is 1 (or the step budget is exhausted), and counts the shifts. The normalized value and shift count are exposed to downstream logic once `datapath_done` is high.

## Interface
- `WIDTH`, default 8: operand/T register width (≥2).
- `CNT_W`, default 3: shift-count width, equal to $clog2(WIDTH).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `load_t`  in  1  T register write enable from the controller.
- `sel_t`  in  1  T source select: 0 = `data_in` (initial load), 1 = T shifted left by 1 (iterate).
- `data_in`  in  WIDTH  operand to normalize.
- `t_out`  out  WIDTH  current T register contents.
- `shift_count`  out  CNT_W  number of shifts applied since the last initial load.
- `datapath_done`  out  1  normalization finished (combinational from registered state).
- `zero_out`  out  1  operand was zero (only with `NORM_ZERO_DETECT_EN`; otherwise tied 0).

## Operation
- Priority per edge: reset > initial load > shift > hold.
- Reset (`rst`=0): T←0, count←0, zero flag←0.
- Initial load (`load_t`=1, `sel_t`=0): T←`data_in`, count←0; allowed at any time, including mid-run (restarts the operation).
- Shift (`load_t`=1, `sel_t`=1, `datapath_done`=0): T←{T[WIDTH-2:0],1'b0}, count←count+1.
- Shift request while `datapath_done`=1: ignored; T and count hold (never over-shift, count never wraps).
- `load_t`=0: T and count hold regardless of `sel_t`.
- `datapath_done` = T[WIDTH-1] OR (count == WIDTH-1) [OR zero flag, see Configuration].
- Count width rule: count ≤ WIDTH-1 always; saturation is enforced by the done-gating of shifts, not by wrap.

## Timing
- Initial load: T and count valid one cycle after the strobe edge; `datapath_done` valid in the same cycle as the new T (no extra latency).
- Each shift: one cycle per strobe; an operand whose leading 1 is at bit k needs WIDTH-1-k shift strobes.
- `datapath_done` is a pure function of registers: glitch-free relative to `clk`, sampled by the controller on the next edge.
- Outputs after reset: `t_out`=0, `shift_count`=0, `zero_out`=0; `datapath_done`=0 without the macro, 1 with it (T=0 treated as a zero operand).
- Simultaneous `load_t`&`sel_t`=0 with `rst`=0: reset wins.

## Configuration
- `NORM_ZERO_DETECT_EN` defined: on initial load, zero flag←(`data_in`==0); `zero_out` = zero flag; flag also forces `datapath_done`=1 so a zero operand finishes with 0 shifts. After reset, flag←0 but done=1 because T==0 is included in the done term when the macro is set.
- Not defined: no zero flag register; `zero_out`=0; a zero operand shifts until count = WIDTH-1 (T stays 0).

## Structure
- Shared package: `NORM_WIDTH` and `NORM_CNT_W` constants, and the `sel_t` encoding constants (`SEL_LOAD`=0, `SEL_SHIFT`=1) shared with the controller.
- One sub-module: `sync_reg_n`, a parameterized register with synchronous active-low reset and enable, instantiated for T, count and (conditionally) the zero flag.
- Next-T mux, incrementer and done logic live in the top module.

## Test plan
- Reset: hold `rst`=0 two cycles → `t_out`=0x00, `shift_count`=0, `zero_out`=0, `datapath_done`=0 (1 with macro).
- Load 0x13, then 3 shift strobes → T: 0x26, 0x4C, 0x98; count 3; `datapath_done` rises with 0x98; a 4th strobe leaves 0x98/3.
- Load 0x80 → `datapath_done`=1 next cycle, count 0; 5 shift strobes → no change.
- Load 0x01, 7 shift strobes → T=0x80, count 7, done=1; an 8th strobe ignored (count does not wrap to 0).
- Load 0x00: macro on → done=1, `zero_out`=1, count 0 immediately; macro off → 7 strobes to done with T=0x00, count 7.
- Mid-run: load 0x05, 2 shifts (T=0x14), then reload 0x40 → T=0x40, count 0, one shift → 0x80 done; separately `rst`=0 at count 2 → all outputs to reset values next edge.

Source files
------------

// File: rtl/norm_datapath_pkg.sv
// norm_datapath_pkg: constants shared between the normalizing datapath and
// the controller that drives it.
//   NORM_WIDTH  default operand / T register width
//   NORM_CNT_W  default shift-count width ($clog2(NORM_WIDTH))
//   SEL_LOAD    sel_t value selecting data_in (initial load)
//   SEL_SHIFT   sel_t value selecting T << 1 (iterate)
package norm_datapath_pkg;

  localparam int NORM_WIDTH = 8;
  localparam int NORM_CNT_W = $clog2(NORM_WIDTH);

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;

endpackage

// File: rtl/norm_datapath_sync_reg_n.sv
// sync_reg_n: W-bit register with synchronous active-low reset and enable.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset, loads RST_VAL
//   en   write enable
//   d    next value
//   q    registered value
module sync_reg_n #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/norm_datapath.sv
// norm_datapath: iterative left-normalizer. Captures an operand into T, then
// shifts T left one bit per controller strobe until its MSB is set or the
// step budget (WIDTH-1 shifts) is spent, counting the shifts.
// Optional feature macro: NORM_ZERO_DETECT_EN (zero-operand detection).
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   load_t         T write enable from the controller
//   sel_t          T source: SEL_LOAD = data_in, SEL_SHIFT = T << 1
//   data_in        operand to normalize
//   t_out          current T contents
//   shift_count    shifts applied since the last initial load
//   datapath_done  normalization finished (decoded from registers only)
//   zero_out       operand was zero (tied 0 without NORM_ZERO_DETECT_EN)
module norm_datapath
  import norm_datapath_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int CNT_W = NORM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_t,
  input  logic             sel_t,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] t_out,
  output logic [CNT_W-1:0] shift_count,
  output logic             datapath_done,
  output logic             zero_out
);

  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] t_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_init;
  logic             shift_go;
  logic             upd_en;
  logic             cnt_max;

  assign load_init = load_t && (sel_t == SEL_LOAD);
  // Shifts are gated by done so T never over-shifts and the count saturates
  // at WIDTH-1 instead of wrapping.
  assign shift_go  = load_t && (sel_t == SEL_SHIFT) && !datapath_done;
  assign upd_en    = load_init || shift_go;

  assign t_d   = load_init ? data_in : {t_q[WIDTH-2:0], 1'b0};
  assign cnt_d = load_init ? '0 : cnt_q + CNT_W'(1);

  assign cnt_max = (cnt_q == CNT_W'(WIDTH - 1));

  sync_reg_n #(.W(WIDTH)) u_t_reg (
    .clk (clk),
    .rst (rst),
    .en  (upd_en),
    .d   (t_d),
    .q   (t_q)
  );

  sync_reg_n #(.W(CNT_W)) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .en  (upd_en),
    .d   (cnt_d),
    .q   (cnt_q)
  );

`ifdef NORM_ZERO_DETECT_EN
  logic zero_q;
  logic zero_d;

  assign zero_d = (data_in == '0);

  sync_reg_n #(.W(1)) u_zero_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_init),
    .d   (zero_d),
    .q   (zero_q)
  );

  // T == 0 term makes the post-reset state read as a finished zero operand
  // even though the flag itself resets to 0.
  assign datapath_done = t_q[WIDTH-1] || cnt_max || zero_q || (t_q == '0);
  assign zero_out      = zero_q;
`else
  assign datapath_done = t_q[WIDTH-1] || cnt_max;
  assign zero_out      = 1'b0;
`endif

  assign t_out       = t_q;
  assign shift_count = cnt_q;

endmodule
